// File: rtl/timer_arbiter_pkg.sv
// Shared constants and types for the interval-timer arbiter.
package timer_arbiter_pkg;

    localparam int TA_NREQ_DEFAULT  = 4;
    localparam int TA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ta_state_e;

    // Width of a requester index; never zero so a single requester still gets a 1-bit index.
    function automatic int ta_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request strictly after
// index last (wrapping to 0) wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [NREQ-1:0] winner_o,
    output logic            valid_o
);

    // Scan from the farthest candidate back to the nearest so the nearest asserted one is kept.
    always_comb begin
        winner_o = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % NREQ]) begin
                winner_o = '0;
                winner_o[(int'(last_i) + k) % NREQ] = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter handing a single interval counter to NREQ requesters.
// Winner owns the counter for target+1 RUN cycles, then receives a done pulse.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int NREQ  = TA_NREQ_DEFAULT,
    parameter int WIDTH = TA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    localparam int IDXW = ta_idx_width(NREQ);

    ta_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [NREQ-1:0]  owner_q, owner_d;
    logic [IDXW-1:0]  owner_idx_q, owner_idx_d;
    logic [IDXW-1:0]  last_q, last_d;

    logic [NREQ-1:0]  pick;
    logic             pick_valid;
    logic [IDXW-1:0]  pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (pick),
        .valid_o  (pick_valid)
    );

    // Encode the one-hot winner into an index for len slicing and last tracking.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IDXW'(i);
        end
    end

    // State registers; last starts at NREQ-1 so index 0 is favoured after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            target_q    <= '0;
            owner_q     <= '0;
            owner_idx_q <= '0;
            last_q      <= IDXW'(NREQ - 1);
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            target_q    <= target_d;
            owner_q     <= owner_d;
            owner_idx_q <= owner_idx_d;
            last_q      <= last_d;
        end
    end

    // Next-state: grant from IDLE, count in RUN (abort beats completion), one-cycle DONE.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        target_d    = target_q;
        owner_d     = owner_q;
        owner_idx_d = owner_idx_q;
        last_d      = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d     = ST_RUN;
                    count_d     = '0;
                    target_d    = len[int'(pick_idx)*WIDTH +: WIDTH];
                    owner_d     = pick;
                    owner_idx_d = pick_idx;
                end
            end
            ST_RUN: begin
                if ((req & owner_q) == '0) begin
                    // Requester withdrew: drop the interval, keep count, leave last alone.
                    state_d = ST_IDLE;
                    owner_d = '0;
                end else if (count_q == target_q) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = owner_idx_q;
                owner_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt   = (state_q == ST_RUN)  ? owner_q : '0;
    assign done  = (state_q == ST_DONE) ? owner_q : '0;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized and directed bench for timer_arbiter against an interval-level reference model.
module tb_timer_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;

    timer_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one optional interval in flight plus a pending completion pulse.
    bit m_active;      // an owner currently holds the counter
    bit m_pulse;       // interval just finished; done is showing this cycle
    int m_w;           // owner index
    int m_len;         // interval length latched at grant
    int m_cnt;         // visible counter value
    int m_last;        // previous completed owner

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pulse  = 0;
        m_w      = 0;
        m_len    = 0;
        m_cnt    = 0;
        m_last   = NREQ - 1;
    endtask

    // Apply the arbitration rules for one rising edge using the inputs seen at that edge.
    task automatic model_edge();
        if (m_pulse) begin
            m_pulse = 0;
            m_last  = m_w;
        end else if (m_active) begin
            if (!req[m_w]) begin
                m_active = 0;
                $display("txn cyc=%0d abort   w=%0d count=%0d", cyc, m_w, m_cnt);
            end else if (m_cnt == m_len) begin
                m_active = 0;
                m_pulse  = 1;
                $display("txn cyc=%0d done    w=%0d len=%0d", cyc, m_w, m_len);
            end else begin
                m_cnt++;
            end
        end else if (req != '0) begin
            for (int k = NREQ; k >= 1; k--) begin
                if (req[(m_last + k) % NREQ]) m_w = (m_last + k) % NREQ;
            end
            m_len    = int'(len[m_w*WIDTH +: WIDTH]);
            m_cnt    = 0;
            m_active = 1;
            $display("txn cyc=%0d grant   w=%0d len=%0d", cyc, m_w, m_len);
        end
    endtask

    task automatic compare(input string ph);
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_done;
        e_gnt  = m_active ? (NREQ'(1) << m_w) : '0;
        e_done = m_pulse  ? (NREQ'(1) << m_w) : '0;
        chk({ph, ".gnt"},   32'(gnt),   32'(e_gnt));
        chk({ph, ".done"},  32'(done),  32'(e_done));
        chk({ph, ".busy"},  32'(busy),  32'(m_active | m_pulse));
        chk({ph, ".count"}, 32'(count), 32'(m_cnt));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        cyc++;
        if (!reset) model_edge();
        #1;
        compare(ph);
    endtask

    task automatic set_len(input int i, input int v);
        len[i*WIDTH +: WIDTH] = WIDTH'(v);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic pulse_reset(input string ph);
        reset = 1'b1;
        #1;
        model_reset();
        compare({ph, ".async"});
        repeat (2) @(posedge clk);
        #1;
        compare({ph, ".held"});
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        len   = '0;
        model_reset();
        #2;
        compare("rst0");
        chk("rst0.gnt_const",   32'(gnt),   32'd0);
        chk("rst0.count_const", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("idle");

        // Single request, length 3.
        set_len(0, 3);
        req = 4'b0001;
        repeat (6) step("single");
        req = '0;
        repeat (2) step("single");

        // Full round robin, all lengths 1.
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        req = 4'b1111;
        repeat (22) step("rr");
        req = '0;
        repeat (3) step("rr");

        // Zero-length interval.
        set_len(2, 0);
        req = 4'b0100;
        repeat (4) step("zero");
        req = '0;
        repeat (2) step("zero");

        // Abort at count 4, then see where the next search starts.
        set_len(1, 10);
        req = 4'b0010;
        for (int n = 0; n < 30; n++) begin
            if (m_active && m_cnt == 4) break;
            step("abort");
        end
        chk("abort.reached4", 32'(count), 32'd4);
        req = '0;
        repeat (2) step("abort");
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        req = 4'b1111;
        repeat (6) step("abort.next");
        req = '0;
        repeat (4) step("abort.next");

        // Reset in the middle of an interval.
        set_len(0, 20);
        req = 4'b0001;
        for (int n = 0; n < 30; n++) begin
            if (m_active && m_cnt == 5) break;
            step("rstrun");
        end
        chk("rstrun.reached5", 32'(count), 32'd5);
        req = '0;
        pulse_reset("rstrun");
        set_len(3, 3);
        req = 4'b1000;
        repeat (6) step("rstrun.after");
        req = '0;
        repeat (2) step("rstrun.after");

        // Maximum length: 256 RUN cycles without wrap.
        set_len(0, 255);
        req = 4'b0001;
        repeat (258) step("max");
        req = '0;
        repeat (3) step("max");

        // Random traffic with len changing every cycle and rare resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
                set_len(i, int'($urandom_range(0, 6)));
            end
            if ($urandom_range(0, 599) == 0) pulse_reset("rand.rst");
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
